// File: rtl/tile_num_digits.sv
// rtl/tile_num_digits.sv - binary to blanked decimal char codes for the tile text renderer
//
// Iterative double-dabble conversion, one input bit per clock, start/done handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, value    conversion request and binary value (captured when accepted in IDLE)
//   busy            high from the cycle after an accepted start through the done cycle
//   done            one-cycle pulse when digits/ndigits/ovf are updated
//   digits          per-digit char codes, units in [3:0]; leading zeros replaced by BLANK
//   ndigits         number of significant digits (1..DIGITS)
//   ovf             value did not fit in DIGITS decimal digits; digits saturated to 9s
module tile_num_digits #(
    parameter int          VAL_W  = 16,
    parameter int          DIGITS = 5,
    parameter logic [3:0]  BLANK  = 4'hA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            ndigits,
    output logic                  ovf
);

    // One spare nibble above the visible digits catches overflow.
    localparam int SW = (DIGITS + 1) * 4;
    localparam int CW = $clog2(VAL_W + 1);
    localparam logic [4*DIGITS-1:0] RESET_DIGITS = {{(DIGITS-1){BLANK}}, 4'd0};

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t            state;
    logic [VAL_W-1:0]  shift_reg;
    logic [SW-1:0]     bcd;
    logic [CW-1:0]     cnt;
    // Remembers a carry out of the spare nibble, so values far beyond
    // the scratch range still report overflow instead of wrapping.
    logic              sticky;

    logic [SW-1:0]     bcd_adj;
    logic [SW-1:0]     bcd_next;

    logic [4*DIGITS-1:0] fmt_digits;
    logic [3:0]          fmt_nd;
    logic                fmt_ovf;

    // Add-3 correction on every nibble >= 5, then shift in the next value bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[SW-2:0], shift_reg[VAL_W-1]};
    end

    // Finished scratch -> renderer codes with leading-zero blanking and saturation.
    always_comb begin
        fmt_ovf    = sticky | (bcd[SW-1 -: 4] != 4'd0);
        fmt_nd     = 4'd1;
        fmt_digits = {DIGITS{BLANK}};
        for (int k = 1; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                fmt_nd = 4'(k + 1);
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (k < int'(fmt_nd)) begin
                fmt_digits[4*k +: 4] = bcd[4*k +: 4];
            end
        end
        if (fmt_ovf) begin
            fmt_nd     = 4'(DIGITS);
            fmt_digits = {DIGITS{4'd9}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            digits    <= RESET_DIGITS;
            ndigits   <= 4'd1;
            shift_reg <= '0;
            bcd       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= value;
                        bcd       <= '0;
                        sticky    <= 1'b0;
                        cnt       <= CW'(VAL_W);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        bcd       <= bcd_next;
                        shift_reg <= {shift_reg[VAL_W-2:0], 1'b0};
                        sticky    <= sticky | bcd_adj[SW-1];
                        cnt       <= cnt - CW'(1);
                    end else begin
                        // All bits consumed: publish, done is high during FINISH
                        // so a start coinciding with done is ignored.
                        digits  <= fmt_digits;
                        ndigits <= fmt_nd;
                        ovf     <= fmt_ovf;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
